struct_deserializer: RTL and testbench
======================================

Name: struct_deserializer

Overview:
- Receive end of the packed-struct path: takes a serial bit stream framed by start-of-frame and rebuilds one packed struct word per frame.
- The struct is {hi, lo}, with hi in the MSBs, laid out exactly as the packer builds it.
- Unpacks the word into its fields, holds them in a single-entry output buffer with a valid/ready handshake, and counts framing errors.

Parameters:
- HI_W, 2, width of struct field hi (>=1)
- LO_W, 2, width of struct field lo (>=1)
- W, HI_W+LO_W, derived total packed width (>=2); not overridable
- CNT_W, 8, width of the saturating error counter

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  serial bit valid
- in_ready  output  1  block can accept a bit this cycle
- in_bit  input  1  serial data, MSB of struct first
- in_sof  input  1  qualifies in_bit as first bit of a frame
- out_valid  output  1  assembled struct available
- out_ready  input  1  consumer accepts struct
- out_word  output  W  full packed struct
- out_hi  output  HI_W  out_word[W-1:LO_W]
- out_lo  output  LO_W  out_word[LO_W-1:0]
- err_cnt  output  CNT_W  saturating framing-error count

Behaviour:
- Reset (async assert, sync-deassert use is the integrator's job):
  - state=IDLE, shift register=0, bit count=0.
  - out_valid=0, out_word=0 (so out_hi=0, out_lo=0), err_cnt=0, in_ready=1.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output accept = out_valid & out_ready.
  - in_ready = (state != HOLD). It is registered-state-derived and never depends on in_valid.
- States and transitions:
  - IDLE:
    - Accept with in_sof=1: shreg <= {shreg[W-2:0], in_bit}, cnt <= 1, go SHIFT.
    - Accept with in_sof=0: bit dropped, err_cnt++, stay IDLE.
  - SHIFT:
    - Accept with in_sof=0: shift in the bit, cnt++.
    - If that accept makes cnt reach W: load out_word <= {shreg[W-2:0], in_bit}, out_valid <= 1, cnt <= 0, go HOLD.
    - Accept with in_sof=1 (resync): err_cnt++, discard the partial frame, treat the bit as the first bit of a new frame (cnt <= 1, stay SHIFT).
    - No accept: hold all state.
  - HOLD:
    - in_ready=0; out_word stable; out_valid=1.
    - On output accept: out_valid <= 0, go IDLE. in_ready is 1 from the next cycle; there is no same-cycle pass-through.
- Latency:
  - out_valid rises on the clock edge that accepts the W-th bit, so it is visible the cycle after that handshake.
  - Minimum frame period is W+1 cycles with out_ready tied high.
- out_word holds its last value after out_valid falls and only updates on frame completion.
- err_cnt saturates at 2^CNT_W-1 and never wraps.
- in_valid=0 never changes state, regardless of in_bit or in_sof.
- in_sof is ignored when in_valid=0.
- Reset mid-frame or while in HOLD: the partial frame or held word is lost and all outputs return to their reset values immediately, without waiting for clk.
- Field mapping is fixed: out_hi is the first HI_W bits received, out_lo is the last LO_W bits.

Test Plan:
- Defaults, out_ready=1. Send frame 1,1,0,1 (sof on first bit) on consecutive cycles → one cycle after the 4th accept: out_valid=1, out_word=4'hd, out_hi=2'b11, out_lo=2'b01, err_cnt=0.
- out_ready=0. Send frame 4'hd, then keep in_valid=1 → in_ready=0 and out_word=4'hd stable for 10 cycles. Raise out_ready → out_valid drops next cycle, in_ready=1; the next frame 4'h6 gives out_word=4'h6.
- Send bits 1,0 (no sof), then frame 4'hd → two drops, err_cnt=2, out_word=4'hd.
- Send sof+1,0, then sof+1,1,0,1 → resync, err_cnt=1, out_word=4'hd (not 4'hb), exactly one out_valid pulse.
- Assert rst_n=0 after 2 bits of a frame and also while in HOLD → out_valid=0, out_word=0, in_ready=1 with no clk edge needed. A fresh frame after reset decodes correctly.
- CNT_W=2. Send 5 non-sof bits in IDLE → err_cnt sequence 1,2,3,3,3 (saturates at 3).

Source files
------------

// File: rtl/struct_deserializer.sv
// Serial-to-packed-struct receiver: rebuilds one {hi, lo} word per SOF-framed bit stream,
// presents it through a single-entry valid/ready buffer and counts framing errors.
module struct_deserializer #(
  parameter int unsigned HI_W  = 2,
  parameter int unsigned LO_W  = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_bit,
  input  logic                  in_sof,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [HI_W+LO_W-1:0]  out_word,
  output logic [HI_W-1:0]       out_hi,
  output logic [LO_W-1:0]       out_lo,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int unsigned W    = HI_W + LO_W;
  localparam int unsigned BC_W = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    shreg;
  logic [BC_W-1:0] cnt;
  logic [W-1:0]    shifted;
  logic            err_inc;

  assign shifted = {shreg[W-2:0], in_bit};

  // Framing error: a non-SOF bit while idle, or an SOF that cuts a frame short.
  assign err_inc = in_valid & ((state == IDLE & ~in_sof) | (state == SHIFT & in_sof));

  // in_ready mirrors state != HOLD and is updated alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_sof) begin
            shreg <= shifted;
            cnt   <= BC_W'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (in_valid) begin
            shreg <= shifted;
            if (in_sof) begin
              cnt <= BC_W'(1);
            end else if (cnt == BC_W'(W - 1)) begin
              out_word  <= shifted;
              out_valid <= 1'b1;
              cnt       <= '0;
              in_ready  <= 1'b0;
              state     <= HOLD;
            end else begin
              cnt <= cnt + BC_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Saturating framing-error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_inc && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign out_hi = out_word[W-1:LO_W];
  assign out_lo = out_word[LO_W-1:0];

endmodule

// File: tb/tb_struct_deserializer.sv
// Directed bench for struct_deserializer: expected words queued at send time and checked
// as the DUT hands them out; a second instance with CNT_W=2 covers counter saturation.
module tb_struct_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_bit, in_sof, out_ready;
  logic       in_ready, out_valid;
  logic [3:0] out_word;
  logic [1:0] out_hi, out_lo;
  logic [7:0] err_cnt;

  logic       in_ready2, out_valid2;
  logic [3:0] out_word2;
  logic [1:0] out_hi2, out_lo2;
  logic [1:0] err_cnt2;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] sb[$];

  always #5 clk = ~clk;

  struct_deserializer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_bit(in_bit), .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_hi(out_hi), .out_lo(out_lo), .err_cnt(err_cnt)
  );

  struct_deserializer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_bit(in_bit), .in_sof(in_sof), .out_valid(out_valid2), .out_ready(out_ready),
    .out_word(out_word2), .out_hi(out_hi2), .out_lo(out_lo2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit and return 1 time unit after the edge that samples it.
  task automatic send_bit(input logic b, input logic sof);
    in_valid = 1'b1;
    in_bit   = b;
    in_sof   = sof;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] w, input bit push);
    if (push) sb.push_back(w);
    for (int i = 3; i >= 0; i--) send_bit(w[i], i == 3);
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_word"},  32'(out_word),  32'd0);
    chk({tag, "_out_hi"},    32'(out_hi),    32'd0);
    chk({tag, "_out_lo"},    32'(out_lo),    32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
    chk({tag, "_err_cnt2"},  32'(err_cnt2),  32'd0);
    chk({tag, "_in_ready2"}, 32'(in_ready2), 32'd1);
    chk({tag, "_out_valid2"},32'(out_valid2),32'd0);
    chk({tag, "_out_word2"}, 32'({out_hi2, out_lo2} | out_word2), 32'd0);
  endtask

  // Async reset away from any clock edge, then realign to posedge+1.
  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs(tag);
    sb.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every output handshake must match the oldest queued frame.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL unexpected_out observed=%0h expected=none", out_word);
      end else begin
        logic [3:0] e;
        e = sb.pop_front();
        chk("sb_word", 32'(out_word), 32'(e));
        chk("sb_hi",   32'(out_hi),   32'(e[3:2]));
        chk("sb_lo",   32'(out_lo),   32'(e[1:0]));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    #12;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame with out_ready high.
    send_frame(4'hd, 1'b1);
    in_valid = 1'b0;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_word",  32'(out_word),  32'hd);
    chk("t1_out_hi",    32'(out_hi),    32'h3);
    chk("t1_out_lo",    32'(out_lo),    32'h1);
    chk("t1_err_cnt",   32'(err_cnt),   32'd0);
    chk("t1_in_ready_hold", 32'(in_ready), 32'd0);
    idle_cycles(1);
    chk("t1_drop_valid", 32'(out_valid), 32'd0);
    chk("t1_in_ready_back", 32'(in_ready), 32'd1);
    chk("t1_word_held", 32'(out_word), 32'hd);

    // Back-pressure: HOLD ignores inputs and keeps the word stable.
    do_reset("rst_a");
    out_ready = 1'b0;
    send_frame(4'hd, 1'b1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'($urandom_range(1));
      in_sof   = 1'($urandom_range(1));
      chk("t2_in_ready",  32'(in_ready),  32'd0);
      chk("t2_out_valid", 32'(out_valid), 32'd1);
      chk("t2_out_word",  32'(out_word),  32'hd);
      @(posedge clk);
      #1;
    end
    chk("t2_err_cnt", 32'(err_cnt), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t2_release_valid", 32'(out_valid), 32'd0);
    chk("t2_release_ready", 32'(in_ready),  32'd1);
    send_frame(4'h6, 1'b1);
    in_valid = 1'b0;
    chk("t2_second_word", 32'(out_word), 32'h6);
    chk("t2_second_hi",   32'(out_hi),   32'h1);
    chk("t2_second_lo",   32'(out_lo),   32'h2);
    idle_cycles(1);

    // Stray bits in IDLE are dropped and counted.
    do_reset("rst_b");
    send_bit(1'b1, 1'b0);
    chk("t3_err1", 32'(err_cnt), 32'd1);
    send_bit(1'b0, 1'b0);
    chk("t3_err2", 32'(err_cnt), 32'd2);
    send_frame(4'hd, 1'b1);
    in_valid = 1'b0;
    chk("t3_word", 32'(out_word), 32'hd);
    chk("t3_err",  32'(err_cnt),  32'd2);
    idle_cycles(1);

    // Resync: SOF mid-frame restarts the frame.
    do_reset("rst_c");
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_frame(4'hd, 1'b1);
    in_valid = 1'b0;
    chk("t4_word",  32'(out_word),  32'hd);
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_err",   32'(err_cnt),   32'd1);
    idle_cycles(3);
    chk("t4_single_pulse", 32'(sb.size()), 32'd0);

    // Async reset mid-frame and while holding a word.
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    do_reset("rst_mid");
    out_ready = 1'b0;
    send_frame(4'h5, 1'b1);
    in_valid = 1'b0;
    chk("t5_hold_valid", 32'(out_valid), 32'd1);
    do_reset("rst_hold");
    out_ready = 1'b1;
    send_frame(4'h9, 1'b1);
    in_valid = 1'b0;
    chk("t5_fresh_word", 32'(out_word), 32'h9);
    chk("t5_fresh_hi",   32'(out_hi),   32'h2);
    chk("t5_fresh_lo",   32'(out_lo),   32'h1);
    idle_cycles(1);

    // Saturation: 2-bit counter sticks at 3, 8-bit counter keeps counting.
    do_reset("rst_d");
    for (int i = 1; i <= 5; i++) begin
      send_bit(1'($urandom_range(1)), 1'b0);
      chk("t6_err_sat", 32'(err_cnt2), (i >= 3) ? 32'd3 : 32'(i));
      chk("t6_err_wide", 32'(err_cnt), 32'(i));
    end
    idle_cycles(2);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
